// File: rtl/pwm_carrier_gen.sv
// PWM carrier generator: one prescaled triangle / saw-up / saw-down carrier per inverter group.
// Latency: all outputs registered; carrier, direction and event pulses change one clk after the deciding edge.
// Backpressure: none; the carrier free-runs while en=1 and parks at 0 while en=0.
//
// Ports:
//   clk, rst          200 MHz clock, asynchronous active-high reset
//   en                run enable; low parks the carrier at 0 and makes the active regs track the inputs
//   mode              00 triangle, 01 saw-up, 10 saw-down, 11 triangle
//   divider           prescale; one carrier tick every divider+1 clks
//   carrier_max       carrier peak value
//   sync_in           (only with CARRIER_SYNC_IN_EN defined) forces an immediate period restart
//   carrier, dir_up   carrier count and counting direction
//   evt_peak          1-clk pulse in the cycle the carrier first becomes max
//   evt_valley        1-clk pulse in the cycle the carrier becomes 0 at a period boundary
//   update_ack        1-clk pulse in the cycle the shadowed divider/max/mode become active
//
// Build option: define CARRIER_SYNC_IN_EN to add the sync_in phase-alignment input.

module pwm_carrier_gen #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] divider,
  input  logic [CNT_W-1:0] carrier_max,
`ifdef CARRIER_SYNC_IN_EN
  input  logic             sync_in,
`endif
  output logic [CNT_W-1:0] carrier,
  output logic             dir_up,
  output logic             evt_peak,
  output logic             evt_valley,
  output logic             update_ack
);

  localparam logic [1:0] MODE_SUP = 2'b01;
  localparam logic [1:0] MODE_SDN = 2'b10;

  logic [CNT_W-1:0] carrier_q, carrier_d;
  logic             dir_up_q, dir_up_d;
  logic             peak_q, peak_d;
  logic             valley_q, valley_d;
  logic             ack_q, ack_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] act_max_q, act_max_d;
  logic [DIV_W-1:0] act_div_q, act_div_d;
  logic [1:0]       act_mode_q, act_mode_d;

  logic             sync_req;
  logic             load;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_dec;

`ifdef CARRIER_SYNC_IN_EN
  assign sync_req = sync_in;
`else
  assign sync_req = 1'b0;
`endif

  // Increment is only used when carrier < max, so it never wraps even at max = all-ones.
  assign cnt_inc = carrier_q + 1'b1;
  assign cnt_dec = carrier_q - 1'b1;

  always_comb begin
    carrier_d  = carrier_q;
    dir_up_d   = dir_up_q;
    div_cnt_d  = div_cnt_q;
    act_max_d  = act_max_q;
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    peak_d     = 1'b0;
    valley_d   = 1'b0;
    ack_d      = 1'b0;
    load       = 1'b0;

    if (!en) begin
      // Parked: a saw-down carrier sits at 0 so its first tick wraps to max as a boundary.
      carrier_d  = '0;
      dir_up_d   = (mode != MODE_SDN);
      div_cnt_d  = '0;
      act_max_d  = carrier_max;
      act_div_d  = divider;
      act_mode_d = mode;
    end else if (sync_req) begin
      load = 1'b1;
    end else if (div_cnt_q != act_div_q) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end else begin
      div_cnt_d = '0;
      if (act_max_q == '0) begin
        // Degenerate carrier: every tick closes a period.
        load = 1'b1;
      end else if (act_mode_q == MODE_SUP) begin
        if (carrier_q >= act_max_q) begin
          load = 1'b1;
        end else begin
          carrier_d = cnt_inc;
          peak_d    = (cnt_inc == act_max_q);
        end
      end else if (act_mode_q == MODE_SDN) begin
        if (carrier_q == '0) begin
          load = 1'b1;
        end else begin
          carrier_d = cnt_dec;
        end
      end else begin
        // Triangle (modes 00 and 11).
        if (dir_up_q) begin
          if (carrier_q >= act_max_q) begin
            dir_up_d  = 1'b0;
            carrier_d = cnt_dec;
            load      = (cnt_dec == '0);
          end else begin
            carrier_d = cnt_inc;
            peak_d    = (cnt_inc == act_max_q);
          end
        end else begin
          if (carrier_q == '0) begin
            dir_up_d  = 1'b1;
            carrier_d = cnt_inc;
            peak_d    = (cnt_inc == act_max_q);
          end else begin
            carrier_d = cnt_dec;
            load      = (cnt_dec == '0);
          end
        end
      end
    end

    // Period boundary (or forced sync): shadow values go live and pick the restart point.
    if (load) begin
      act_max_d  = carrier_max;
      act_div_d  = divider;
      act_mode_d = mode;
      div_cnt_d  = '0;
      ack_d      = 1'b1;
      if (mode == MODE_SDN && carrier_max != '0) begin
        carrier_d = carrier_max;
        dir_up_d  = 1'b0;
        peak_d    = 1'b1;
        valley_d  = 1'b0;
      end else begin
        carrier_d = '0;
        dir_up_d  = (mode != MODE_SDN);
        peak_d    = 1'b0;
        valley_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier_q  <= '0;
      dir_up_q   <= 1'b1;
      peak_q     <= 1'b0;
      valley_q   <= 1'b0;
      ack_q      <= 1'b0;
      div_cnt_q  <= '0;
      act_max_q  <= '0;
      act_div_q  <= '0;
      act_mode_q <= 2'b00;
    end else begin
      carrier_q  <= carrier_d;
      dir_up_q   <= dir_up_d;
      peak_q     <= peak_d;
      valley_q   <= valley_d;
      ack_q      <= ack_d;
      div_cnt_q  <= div_cnt_d;
      act_max_q  <= act_max_d;
      act_div_q  <= act_div_d;
      act_mode_q <= act_mode_d;
    end
  end

  assign carrier    = carrier_q;
  assign dir_up     = dir_up_q;
  assign evt_peak   = peak_q;
  assign evt_valley = valley_q;
  assign update_ack = ack_q;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Bench for pwm_carrier_gen: directed scenarios with literal expectations plus a
// phase-based carrier model compared against the outputs every clock.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_pwm_carrier_gen;
  localparam int CW = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] divider = '0;
  logic [CW-1:0] carrier_max = '0;
  logic          sync_in = 1'b0;
  logic [CW-1:0] carrier;
  logic          dir_up;
  logic          evt_peak;
  logic          evt_valley;
  logic          update_ack;

  int checks = 0;
  int errors = 0;

  // Model: the carrier is a phase position m_p inside the current period.
  int   m_p = 0;
  int   m_dcnt = 0;
  int   m_amax = 0;
  int   m_adiv = 0;
  int   m_amode = 0;
  logic m_peak = 1'b0;
  logic m_valley = 1'b0;
  logic m_ack = 1'b0;

  int exp1[9]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
  int exp2[15] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};

  pwm_carrier_gen #(.CNT_W(CW), .DIV_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .divider     (divider),
    .carrier_max (carrier_max),
`ifdef CARRIER_SYNC_IN_EN
    .sync_in     (sync_in),
`endif
    .carrier     (carrier),
    .dir_up      (dir_up),
    .evt_peak    (evt_peak),
    .evt_valley  (evt_valley),
    .update_ack  (update_ack)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int nmode(input logic [1:0] m);
    return (m == 2'b11) ? 0 : int'(m);
  endfunction

  function automatic int mperiod();
    if (m_amode == 0) return (m_amax == 0) ? 1 : 2 * m_amax;
    return m_amax + 1;
  endfunction

  function automatic int mcar();
    if (m_amode == 1) return m_p;
    if (m_amode == 2) return m_amax - m_p;
    return (m_p <= m_amax) ? m_p : 2 * m_amax - m_p;
  endfunction

  function automatic int mdir();
    if (m_amode == 1) return 1;
    if (m_amode == 2) return 0;
    return (m_p <= m_amax) ? 1 : 0;
  endfunction

  task automatic mreset();
    m_p = 0; m_dcnt = 0; m_amax = 0; m_adiv = 0; m_amode = 0;
    m_peak = 1'b0; m_valley = 1'b0; m_ack = 1'b0;
  endtask

  task automatic mload();
    m_amax  = int'(carrier_max);
    m_adiv  = int'(divider);
    m_amode = nmode(mode);
    m_p     = 0;
    m_dcnt  = 0;
    m_ack   = 1'b1;
    if (m_amode == 2 && m_amax != 0) m_peak = 1'b1;
    else m_valley = 1'b1;
  endtask

  task automatic mstep();
    m_peak = 1'b0; m_valley = 1'b0; m_ack = 1'b0;
    if (!en) begin
      m_amax  = int'(carrier_max);
      m_adiv  = int'(divider);
      m_amode = nmode(mode);
      m_dcnt  = 0;
      m_p     = (m_amode == 2) ? m_amax : 0;
    end else if (sync_in) begin
      mload();
    end else if (m_dcnt != m_adiv) begin
      m_dcnt++;
    end else begin
      m_dcnt = 0;
      m_p++;
      if (m_p >= mperiod()) mload();
      else if (m_amode != 2 && m_p == m_amax) m_peak = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_carrier", int'(carrier), mcar());
      chk("cmp_dir_up", int'(dir_up), mdir());
      chk("cmp_evt_peak", int'(evt_peak), int'(m_peak));
      chk("cmp_evt_valley", int'(evt_valley), int'(m_valley));
      chk("cmp_update_ack", int'(update_ack), int'(m_ack));
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic park(input logic [1:0] md, input int dv, input int mx);
    en = 1'b0; mode = md; divider = DW'(dv); carrier_max = CW'(mx);
    run(1);
  endtask

  initial begin
    #1 rst = 1'b1;
    run(2);
    rst = 1'b0;
    chk("rst_carrier", int'(carrier), 0);
    chk("rst_dir_up", int'(dir_up), 1);
    chk("rst_peak", int'(evt_peak), 0);
    chk("rst_valley", int'(evt_valley), 0);
    chk("rst_ack", int'(update_ack), 0);

    // Triangle, divider 0, max 4.
    park(2'b00, 0, 4);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run(1);
      chk("tri4_carrier", int'(carrier), exp1[i]);
      if (i == 3) chk("tri4_peak", int'(evt_peak), 1);
      if (i == 7) begin
        chk("tri4_valley", int'(evt_valley), 1);
        chk("tri4_ack", int'(update_ack), 1);
      end
    end

    // Saw-up, divider 2, max 3.
    park(2'b01, 2, 3);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      run(1);
      chk("sup_carrier", int'(carrier), exp2[i]);
      if (i == 8) chk("sup_peak", int'(evt_peak), 1);
      if (i == 11) begin
        chk("sup_valley", int'(evt_valley), 1);
        chk("sup_ack", int'(update_ack), 1);
      end
    end

    // Triangle max 10, max rewritten to 6 mid-period.
    park(2'b00, 0, 10);
    en = 1'b1;
    run(5);  chk("shadow_c5", int'(carrier), 5);
    carrier_max = CW'(6);
    run(5);  chk("shadow_peak10", int'(carrier), 10);
    chk("shadow_peak10_evt", int'(evt_peak), 1);
    chk("shadow_no_early_ack", int'(update_ack), 0);
    run(10); chk("shadow_c0", int'(carrier), 0);
    chk("shadow_ack", int'(update_ack), 1);
    run(6);  chk("shadow_peak6", int'(carrier), 6);
    chk("shadow_peak6_evt", int'(evt_peak), 1);
    run(1);  chk("shadow_c5_down", int'(carrier), 5);
    chk("shadow_dir_down", int'(dir_up), 0);

    // Mode 00 -> 10 written at count 5.
    park(2'b00, 0, 8);
    en = 1'b1;
    run(5);  chk("m2sdn_c5", int'(carrier), 5);
    mode = 2'b10;
    run(11); chk("m2sdn_cmax", int'(carrier), 8);
    chk("m2sdn_dir", int'(dir_up), 0);
    chk("m2sdn_peak", int'(evt_peak), 1);
    chk("m2sdn_ack", int'(update_ack), 1);
    run(1);  chk("m2sdn_c7", int'(carrier), 7);
    run(7);  chk("m2sdn_c0", int'(carrier), 0);
    chk("m2sdn_c0_valley", int'(evt_valley), 0);
    run(1);  chk("m2sdn_wrap", int'(carrier), 8);
    chk("m2sdn_wrap_ack", int'(update_ack), 1);

    // Enable drop at 7, restart, then asynchronous reset mid-count.
    park(2'b00, 1, 10);
    en = 1'b1;
    run(14); chk("en_c7", int'(carrier), 7);
    en = 1'b0;
    run(1);  chk("en_off_c0", int'(carrier), 0);
    chk("en_off_dir", int'(dir_up), 1);
    chk("en_off_valley", int'(evt_valley), 0);
    chk("en_off_ack", int'(update_ack), 0);
    en = 1'b1;
    run(1);  chk("en_on_hold", int'(carrier), 0);
    run(1);  chk("en_on_c1", int'(carrier), 1);
    run(5);
    rst = 1'b1;
    #1;
    chk("arst_carrier", int'(carrier), 0);
    chk("arst_dir", int'(dir_up), 1);
    run(1);
    rst = 1'b0;
    run(1);  chk("post_rst_ack", int'(update_ack), 1);
    chk("post_rst_valley", int'(evt_valley), 1);
    run(2);  chk("post_rst_c1", int'(carrier), 1);

    // Full-range saw-up, max = 2^CW-1.
    park(2'b01, 0, 255);
    en = 1'b1;
    run(255); chk("full_c255", int'(carrier), 255);
    chk("full_peak", int'(evt_peak), 1);
    run(1);   chk("full_wrap", int'(carrier), 0);
    chk("full_valley", int'(evt_valley), 1);
    chk("full_wrap_peak", int'(evt_peak), 0);

    // Triangle max 1.
    park(2'b00, 0, 1);
    en = 1'b1;
    run(1); chk("m1_c1", int'(carrier), 1);
    chk("m1_peak", int'(evt_peak), 1);
    run(1); chk("m1_c0", int'(carrier), 0);
    chk("m1_valley", int'(evt_valley), 1);
    chk("m1_no_peak", int'(evt_peak), 0);
    run(1); chk("m1_peak2", int'(evt_peak), 1);

    // max 0, divider 1: valley on every tick.
    park(2'b00, 1, 0);
    en = 1'b1;
    run(1); chk("m0_no_tick", int'(evt_valley), 0);
    run(1); chk("m0_valley1", int'(evt_valley), 1);
    chk("m0_ack1", int'(update_ack), 1);
    chk("m0_carrier", int'(carrier), 0);
    run(1); chk("m0_gap", int'(evt_valley), 0);
    run(1); chk("m0_valley2", int'(evt_valley), 1);

    // Mode 11 and assorted mode/divider switches, checked by the model only.
    park(2'b11, 0, 5);
    chk("m11_dir", int'(dir_up), 1);
    en = 1'b1;
    run(15);
    mode = 2'b10; carrier_max = CW'(3); divider = DW'(1);
    run(30);
    mode = 2'b01;
    run(30);
    mode = 2'b00; carrier_max = CW'(2); divider = DW'(0);
    run(20);

`ifdef CARRIER_SYNC_IN_EN
    park(2'b00, 0, 8);
    en = 1'b1;
    run(3); chk("sync_c3", int'(carrier), 3);
    sync_in = 1'b1;
    run(1);
    sync_in = 1'b0;
    chk("sync_c0", int'(carrier), 0);
    chk("sync_valley", int'(evt_valley), 1);
    chk("sync_ack", int'(update_ack), 1);
    chk("sync_dir", int'(dir_up), 1);
    run(1); chk("sync_c1", int'(carrier), 1);
    mode = 2'b10; carrier_max = CW'(5);
    sync_in = 1'b1;
    run(1);
    sync_in = 1'b0;
    chk("sync_sdn_cmax", int'(carrier), 5);
    chk("sync_sdn_peak", int'(evt_peak), 1);
    run(12);
`endif

    run(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
